// File: rtl/tx_framer_pkg.sv
// rtl/tx_framer_pkg.sv - shared types and constants for the UART frame transmitter
package tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_TYPE,
    ST_LEN,
    ST_PAY,
    ST_CHK,
    ST_END
  } state_e;

  localparam int CHK_SUM8 = 0;
  localparam int CHK_XOR8 = 1;
  localparam int CHK_CRC8 = 2;

  localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/tx_framer_chk_accum.sv
// rtl/tx_framer_chk_accum.sv - combinational one-byte checksum step (sum8, xor8, CRC-8)
module chk_accum
  import tx_framer_pkg::*;
#(
  parameter int MODE = CHK_SUM8
) (
  input  logic [7:0] chk_i,
  input  logic [7:0] data_i,
  output logic [7:0] chk_o
);

  logic [7:0] crc;

  always_comb begin
    chk_o = chk_i + data_i;
    crc   = chk_i ^ data_i;
    // MSB-first, non-reflected CRC: one shift/conditional-xor per data bit
    for (int b = 0; b < 8; b++) begin
      crc = crc[7] ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
    end
    case (MODE)
      CHK_XOR8: chk_o = chk_i ^ data_i;
      CHK_CRC8: chk_o = crc;
      default:  chk_o = chk_i + data_i;
    endcase
  end

endmodule

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - serialises [SOF][TYPE][LEN][PAYLOAD][CHK] onto a UART byte-strobe interface
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int         MAX_LEN  = 32,
  parameter logic [7:0] SOF_BYTE = 8'hAA,
  parameter int         CHK_MODE = CHK_SUM8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [7:0]           type_byte_i,
  input  logic [7:0]           len_byte_i,
  input  logic [8*MAX_LEN-1:0] payload_bus_i,
  input  logic                 tx_busy_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_strobe_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e               state_q;
  logic [7:0]           type_q, len_q, idx_q, chk_q, tx_data_q;
  logic [8*MAX_LEN-1:0] pay_q;
  logic                 tx_strobe_q, busy_q, done_q, err_q;

  logic       can_issue;
  logic [7:0] cur_byte;
  logic [7:0] chk_d;

  // The gap cycle after every strobe hides the UART's busy-assertion latency
  assign can_issue = !tx_busy_i && !tx_strobe_q;

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      ST_SOF:  cur_byte = SOF_BYTE;
      ST_TYPE: cur_byte = type_q;
      ST_LEN:  cur_byte = len_q;
      ST_PAY:  cur_byte = pay_q[8*idx_q +: 8];
      ST_CHK:  cur_byte = chk_q;
      default: cur_byte = 8'h00;
    endcase
  end

  chk_accum #(.MODE(CHK_MODE)) u_chk (
    .chk_i  (chk_q),
    .data_i (cur_byte),
    .chk_o  (chk_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      type_q      <= 8'h00;
      len_q       <= 8'h00;
      idx_q       <= 8'h00;
      chk_q       <= 8'h00;
      pay_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tx_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_byte_i <= MAX_LEN_B) begin
              type_q  <= type_byte_i;
              len_q   <= len_byte_i;
              pay_q   <= payload_bus_i;
              chk_q   <= 8'h00;
              idx_q   <= 8'h00;
              busy_q  <= 1'b1;
              state_q <= ST_SOF;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (can_issue) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (can_issue) begin
            tx_data_q   <= cur_byte;
            tx_strobe_q <= 1'b1;
            case (state_q)
              ST_SOF:  state_q <= ST_TYPE;
              ST_TYPE: begin
                chk_q   <= chk_d;
                state_q <= ST_LEN;
              end
              ST_LEN: begin
                chk_q   <= chk_d;
                state_q <= (len_q == 8'h00) ? ST_CHK : ST_PAY;
              end
              ST_PAY: begin
                chk_q <= chk_d;
                if (idx_q == len_q - 8'd1) begin
                  state_q <= ST_CHK;
                end else begin
                  idx_q <= idx_q + 8'd1;
                end
              end
              ST_CHK:  state_q <= ST_END;
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_strobe_o = tx_strobe_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/tx_framer.md
# tx_framer

Parametrised UART frame transmitter, replacing the fixed sum-checksum framer. It serialises `[SOF][TYPE][LEN][PAYLOAD 0..LEN-1][CHK]` onto the byte-wide UART transmit strobe interface. It adds a selectable checksum (sum8, xor8 or CRC-8), snapshots the frame fields at start, and guards the byte-strobe handshake against UART busy latency. It has done and error reporting, and sits between the RFID response builder and `uart_tx`.

## Interface
- `MAX_LEN`, 32: maximum payload bytes (1..255); sets `payload_bus` width.
- `SOF_BYTE`, 8'hAA: start-of-frame byte.
- `CHK_MODE`, 0: checksum algorithm. 0 = sum8, 1 = xor8, 2 = CRC-8 (poly 0x07, init 0x00, MSB-first, no reflect, no final xor).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame request, sampled only in IDLE.
- `type_byte` in 8: frame type.
- `len_byte` in 8: payload length, 0..MAX_LEN.
- `payload_bus` in 8*MAX_LEN: byte i = `payload_bus[8*i +: 8]`; byte 0 is sent first.
- `tx_busy` in 1: UART busy; a byte may be issued only while it is low.
- `tx_data` out 8: byte to UART, valid with `tx_strobe`.
- `tx_strobe` out 1: one-cycle load pulse to UART.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States, in order: IDLE, SOF, TYPE, LEN, PAY, CHK, END.
- IDLE to SOF: on `start`, when `len_byte` <= MAX_LEN.
  - Latch `type_byte`, `len_byte` and `payload_bus` into internal registers.
  - Clear the checksum and index; set `busy`.
  - The snapshot is used for the whole frame; input changes after the start edge are ignored.
- Rejected start: when `start` arrives with `len_byte` > MAX_LEN, pulse `err` for 1 cycle, remain in IDLE, and emit no bytes.
- Issue rule for SOF, TYPE, LEN, PAY and CHK: a byte is issued when `tx_busy` == 0 AND no strobe was issued in the previous cycle.
  - Issuing means registering `tx_data` and `tx_strobe` = 1, then advancing.
  - The mandatory gap cycle covers UART busy assertion latency.
- Checksum coverage: TYPE, LEN and every payload byte. SOF is excluded.
  - sum8: modulo-256 addition.
  - xor8: bitwise xor.
  - CRC-8: per byte, `crc ^= b`, then 8 shift/xor steps with poly 0x07.
- Transitions:
  - LEN goes to CHK when the latched length is 0, otherwise to PAY.
  - PAY sends byte `idx`, then increments `idx`. It goes to CHK after byte LEN-1. `idx` is 8 bits and never exceeds MAX_LEN-1.
  - CHK sends the accumulated checksum.
- END: waits for `tx_busy` == 0 and the gap cycle. It then clears `busy`, pulses `done` for 1 cycle, and returns to IDLE.
- `start` while `busy`: ignored, with no error and no queueing.
- Reset mid-frame: the frame is abandoned immediately and no further strobes occur.

## Timing
- Reset values:
  - `tx_data` = 0x00.
  - `tx_strobe`, `busy`, `done` and `err` = 0.
  - state = IDLE; checksum and index = 0.
- Start edge E0: `busy` = 1 from E0. The earliest SOF strobe is high after E1.
- With `tx_busy` held low, strobes come every 2 cycles, at E1, E3, E5, and so on. A frame of N payload bytes produces N+4 strobes.
- `done` is high for one cycle, 2 cycles after the CHK strobe edge (given `tx_busy` low). `busy` falls on the same edge.
- A new `start` is accepted on the cycle after `done`.
- `tx_strobe` is never high on two consecutive cycles, and is never asserted in a cycle where the sampled `tx_busy` = 1.

## Structure
- Package `tx_framer_pkg` holds:
  - the state enum;
  - the `CHK_SUM8`, `CHK_XOR8` and `CHK_CRC8` constants;
  - `CRC8_POLY` = 8'h07.
- Sub-module `chk_accum`, which is combinational. It takes mode (parameter), the current checksum and a data byte, and produces the next checksum. It is reusable by the matching receive-side deframer.

## Test plan
- sum8, type 0x01, len 2, payload 0x10, 0x30, `tx_busy` low: expect bytes AA 01 02 10 30 43, strobes 2 cycles apart, then one `done` pulse.
- xor8 with the same frame: expect AA 01 02 10 30 23.
- CRC-8, type 0x01, len 0: expect AA 01 00 15, with no PAY state visited.
- len 33 with MAX_LEN 32: expect one `err` pulse, no strobes, and `busy` staying 0.
- `tx_busy` held high for 5 cycles after each strobe:
  - no strobe while it is high;
  - byte order intact;
  - payload inputs changed mid-frame do not alter the output.
- Reset (`rst_n` low) during PAY: outputs return to reset values at once; the next `start` sends a complete, correct frame.
